// File: rtl/mem_wb_elastic_reg.sv
// MEM/WB pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer.
// It supports synchronous flush and a saturating stall-cycle counter for performance monitoring.
module mem_wb_elastic_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [REG_W-1:0]  in_wreg,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic [DATA_W-1:0] out_alu,
    output logic [REG_W-1:0]  out_wreg,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PAY_W = CTRL_W + REG_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state_r;
    logic [PAY_W-1:0]  main_r;
    logic [PAY_W-1:0]  skid_r;
    logic              outValid_r;
    logic              inReady_r;
    logic [1:0]        occ_r;
    logic [CNT_W-1:0]  stallCnt_r;
    logic [PAY_W-1:0]  inPay_s;
    logic              inXfer_s;
    logic              outXfer_s;
    logic [CTRL_W-1:0] ctrlGated_s;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign inPay_s   = {in_ctrl, in_wreg, in_alu, in_rdata};
    assign inXfer_s  = in_valid & inReady_r;
    assign outXfer_s = outValid_r & out_ready;

    // Handshake state machine: state, status flags and both payload slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= EMPTY;
            outValid_r <= 1'b0;
            inReady_r  <= 1'b1;
            occ_r      <= 2'd0;
            main_r     <= '0;
            skid_r     <= '0;
        end else if (flush) begin
            // Payload is left stale; out_valid=0 masks it and gates RegWrite.
            state_r    <= EMPTY;
            outValid_r <= 1'b0;
            inReady_r  <= 1'b1;
            occ_r      <= 2'd0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (inXfer_s) begin
                        main_r     <= inPay_s;
                        state_r    <= FULL;
                        outValid_r <= 1'b1;
                        occ_r      <= 2'd1;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                FULL: begin
                    if (inXfer_s && outXfer_s) begin
                        main_r <= inPay_s;
                    end else if (inXfer_s) begin
                        skid_r    <= inPay_s;
                        state_r   <= SKID;
                        inReady_r <= 1'b0;
                        occ_r     <= 2'd2;
                    end else if (outXfer_s) begin
                        state_r    <= EMPTY;
                        outValid_r <= 1'b0;
                        occ_r      <= 2'd0;
                    end else begin
                        state_r <= FULL;
                    end
                end
                SKID: begin
                    if (outXfer_s) begin
                        main_r    <= skid_r;
                        state_r   <= FULL;
                        inReady_r <= 1'b1;
                        occ_r     <= 2'd1;
                    end else begin
                        state_r <= SKID;
                    end
                end
                default: begin
                    state_r    <= EMPTY;
                    outValid_r <= 1'b0;
                    inReady_r  <= 1'b1;
                    occ_r      <= 2'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles where WB holds off a valid payload; survives flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt_r <= '0;
        end else if (outValid_r && !out_ready) begin
            stallCnt_r <= satInc(stallCnt_r);
        end else begin
            stallCnt_r <= stallCnt_r;
        end
    end

    // RegWrite is masked whenever the main slot is not valid.
    always_comb begin
        ctrlGated_s    = main_r[PAY_W-1 -: CTRL_W];
        ctrlGated_s[0] = main_r[PAY_W-CTRL_W] & outValid_r;
    end

    assign in_ready  = inReady_r;
    assign out_valid = outValid_r;
    assign out_rdata = main_r[DATA_W-1:0];
    assign out_alu   = main_r[2*DATA_W-1:DATA_W];
    assign out_wreg  = main_r[2*DATA_W+REG_W-1:2*DATA_W];
    assign out_ctrl  = ctrlGated_s;
    assign occupancy = occ_r;
    assign stall_cnt = stallCnt_r;

endmodule

// File: doc/mem_wb_elastic_reg.md
Name: mem_wb_elastic_reg

Overview:
Parametrised MEM/WB pipeline boundary register for the pipelined MIPS core. It carries read data, ALU result, destination register and control bits from the memory stage to write-back. Flow control uses a valid/ready handshake with a 2-entry skid buffer, so a stalled write-back never drops a transfer. It also supports synchronous flush and a saturating stall-cycle counter for performance monitoring.

Parameters:
DATA_W, 32, width of read-data and ALU-result fields
REG_W, 5, width of destination register index
CTRL_W, 2, width of control field; bit0 = RegWrite, bit1 = MemtoReg
CNT_W, 16, width of stall counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush, active-high
in_valid  input  1  MEM-stage payload valid
in_ready  output  1  block can accept payload this cycle
in_rdata  input  DATA_W  memory read data
in_alu  input  DATA_W  ALU result
in_wreg  input  REG_W  destination register
in_ctrl  input  CTRL_W  control bits
out_valid  output  1  WB payload valid
out_ready  input  1  WB stage consumes payload this cycle
out_rdata  output  DATA_W  registered read data
out_alu  output  DATA_W  registered ALU result
out_wreg  output  REG_W  registered destination
out_ctrl  output  CTRL_W  registered control; bit0 forced 0 when out_valid=0
occupancy  output  2  entries held: 0, 1 or 2
stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (rst=0, async): all payload registers cleared to 0; state EMPTY; out_valid=0; stall_cnt=0; occupancy=0. in_ready reads 1 while in reset.
- Storage: a main register drives the out_* ports. A skid register holds one extra payload.
- in_ready = (state != SKID); combinational from state only, never from out_ready.
- Handshakes: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Latency: 1 cycle from input transfer into EMPTY to out_valid=1.
- States:
  - EMPTY: on input transfer, main <= in and go to FULL.
  - FULL:
    - input and output transfer together: main <= in, stay in FULL.
    - input transfer only: skid <= in, go to SKID.
    - output transfer only: go to EMPTY.
    - neither: hold.
  - SKID: in_ready=0. On output transfer, main <= skid and go to FULL. Otherwise hold.
- Ordering is strictly FIFO: the skid entry is never presented before the main entry.
- Payload is held stable while out_valid=1 and out_ready=0.
- Flush has priority over everything: next state EMPTY, both entries invalidated, no input accepted that cycle. Payload registers may keep stale data, but out_ctrl[0] reads 0 because out_valid=0. stall_cnt is not cleared by flush.
- out_ctrl[0] (RegWrite) is gated with out_valid, so no spurious register-file write is possible.
- occupancy: EMPTY=0, FULL=1, SKID=2.
- stall_cnt increments by 1 each cycle with out_valid=1 and out_ready=0. It saturates at all-ones and does not wrap.
- Reset asserted mid-transfer discards both entries immediately.
- in_* values are ignored when in_valid=0.

Test Plan:
1. Reset, then stream: out_ready=1; push alu=0x10, 0x20, 0x30 on consecutive cycles -> each appears on out_alu 1 cycle later, with out_valid=1 continuously for 3 cycles and occupancy=1.
2. Backpressure:
   - Push 0xA, hold out_ready=0, push 0xB -> occupancy=2 and in_ready=0.
   - Offer 0xC while in_ready=0 -> not accepted.
   - Raise out_ready -> outputs 0xA then 0xB, and in_ready returns to 1 after 0xA leaves.
3. Flush: with occupancy=2, assert flush together with in_valid (alu=0x55) -> next cycle out_valid=0, occupancy=0, out_ctrl[0]=0, and 0x55 never appears.
4. Simultaneous events: in FULL, in_valid=1 and out_ready=1 together -> old entry delivered, new entry in main, occupancy stays 1.
5. Stall counter: out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5. With CNT_W=3 and 10 stall cycles -> stall_cnt=7, held.
6. Async reset: drop rst mid-SKID without a clock edge -> out_valid=0, occupancy=0, all outputs 0 immediately. After release, behaviour is identical to test 1.
